one_hot_ring_monitor: RTL
=========================

Name: one_hot_ring_monitor

Overview:
- Sits directly downstream of the 8-bit one-hot rotating counter and samples its `out` bus every clock.
- Checks that the ring stays legal: exactly one bit set, and each step either holds or rotates left by one (bit i -> bit i+1, bit 7 -> bit 0).
- Encodes the hot position to a binary index, counts full revolutions and watches for stalls.
- Raises sticky fault flags for the controller.

Parameters:
- REV_W, 16: width of the revolution counter.
- STALL_MAX, 255: consecutive non-advancing locked cycles before `stall` asserts; 0 disables stall detection.
- STALL_W, 8: width of the internal hold counter; must satisfy STALL_MAX < 2**STALL_W.

Ports:
- clk  input  1  rising-edge clock, same domain as the counter.
- reset_n  input  1  asynchronous, active-low reset.
- hot_in  input  8  counter output, one-hot ring value.
- up_reset  input  1  the counter's synchronous reset, observed in the same cycle.
- err_clr  input  1  single-cycle clear of sticky flags and FAULT state.
- index  output  3  binary position of the hot bit (0..7).
- index_valid  output  1  high while LOCKED.
- wrap_pulse  output  1  one-cycle pulse on a 7->0 advance.
- rev_count  output  REV_W  completed revolutions, wraps modulo 2**REV_W.
- stall  output  1  hold count reached STALL_MAX while LOCKED.
- err_illegal  output  1  sticky: sample was not exactly one-hot.
- err_skip  output  1  sticky: legal sample, but neither hold nor +1 rotate.

Behaviour:
- Reset values (reset_n low, async): state=UNLOCKED, prev_hot=8'h00, index=0, index_valid=0, wrap_pulse=0, rev_count=0, hold_cnt=0, stall=0, err_illegal=0, err_skip=0.
- All outputs are registered. Each decision uses combinational compare of hot_in against prev_hot. Result is visible on outputs 1 cycle after hot_in is presented.
- legal = popcount(hot_in)==1.
- hold = (hot_in == prev_hot).
- adv = (hot_in == {prev_hot[6:0], prev_hot[7]}).
- States:
  - UNLOCKED:
    - legal -> LOCKED; prev_hot <= hot_in; index <= encode(hot_in); hold_cnt <= 0.
    - illegal -> stay UNLOCKED, no flag (startup tolerance).
  - LOCKED, in priority order:
    - illegal: err_illegal<=1, go to FAULT.
    - adv: prev_hot/index update; hold_cnt<=0; stall<=0.
    - hold: hold_cnt increments, saturating at STALL_MAX.
    - otherwise: err_skip<=1, go to FAULT.
  - FAULT: index_valid=0, index frozen, rev_count frozen, stall=0. err_clr -> UNLOCKED.
- wrap_pulse: asserted for the cycle following an adv where prev_hot[7]=1. rev_count increments at the same time.
- stall: set when hold_cnt==STALL_MAX, unless STALL_MAX==0. Clears on adv, on leaving LOCKED, or on up_reset.
- up_reset high (any state, priority over all except reset_n):
  - next state UNLOCKED; rev_count<=0; hold_cnt<=0; stall<=0.
  - Sticky flags are untouched.
  - hot_in is not checked that cycle.
  - This makes the upstream's return to 8'b0000_0001 never a skip fault.
- err_clr:
  - Clears both sticky flags.
  - If a new error is detected in the same cycle, set wins and the flag stays 1.
  - In FAULT, err_clr moves to UNLOCKED even if hot_in is illegal that cycle.
  - err_clr and up_reset together: state UNLOCKED, flags cleared.
- Wrap boundaries:
  - rev_count wraps all-ones -> 0 silently.
  - index wraps 7->0 with the ring.

Decomposition:
- Shared package `one_hot_pkg`:
  - state enum {UNLOCKED, LOCKED, FAULT};
  - constant RING_W=8;
  - function for one-hot legality (popcount==1);
  - function for rotate-left-by-one.
- One natural sub-module: `one_hot_enc8`, a combinational 8->3 encoder with a `legal` output. Reusable by other ring consumers.

Test Plan:
- Startup: release reset_n, hold up_reset 1 cycle, then hot_in 01,02,04,...,80,01 one per cycle -> index_valid=1 from 2nd cycle; index 0..7,0; one wrap_pulse; rev_count=1; no flags.
- Illegal sample: locked at 8'h04, drive 8'h0C -> next cycle err_illegal=1, index_valid=0, state FAULT. Pulse err_clr, then drive 8'h08 -> relock with index=3.
- Skip: locked at 8'h02, drive 8'h08 -> err_skip=1, FAULT, index frozen at 1. Drive err_clr in the same cycle as an illegal 8'h00 -> err_illegal=0 the next cycle (illegal ignored in FAULT), state UNLOCKED.
- Stall: STALL_MAX=4, hold 8'h10 for 6 cycles -> stall rises on the 5th hold compare. An advance to 8'h20 drops stall the next cycle.
- Upstream reset mid-ring: locked at 8'h40 with rev_count=3; assert up_reset while hot_in=8'h01 -> UNLOCKED, rev_count=0, no err_skip. Next cycle 8'h01 relocks with index=0.
- Async reset mid-operation: assert reset_n low between clock edges while in FAULT with both flags set -> all outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/one_hot_pkg.sv
// Shared definitions for consumers of the 8-bit one-hot rotating ring.
//   RING_W       : ring width (8 bits)
//   ring_state_e : monitor lock state (UNLOCKED / LOCKED / FAULT)
//   is_one_hot() : exactly one bit set
//   rotl1()      : rotate left by one (bit i -> bit i+1, MSB -> bit 0)
package one_hot_pkg;

    localparam int RING_W = 8;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        FAULT    = 2'd2
    } ring_state_e;

    function automatic logic is_one_hot(input logic [RING_W-1:0] v);
        logic [$clog2(RING_W+1)-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < RING_W; i++) begin
            cnt = cnt + ($bits(cnt))'(v[i]);
        end
        return (cnt == ($bits(cnt))'(1));
    endfunction

    function automatic logic [RING_W-1:0] rotl1(input logic [RING_W-1:0] v);
        return {v[RING_W-2:0], v[RING_W-1]};
    endfunction

endpackage

// File: rtl/one_hot_ring_monitor_enc8.sv
// Combinational 8->3 one-hot encoder with a legality flag.
//   hot_i   : candidate one-hot value
//   index_o : binary position of the set bit (only meaningful when legal_o)
//   legal_o : high when exactly one bit of hot_i is set
module one_hot_enc8
    import one_hot_pkg::*;
(
    input  logic [RING_W-1:0] hot_i,
    output logic [2:0]        index_o,
    output logic              legal_o
);

    // OR-ing the positions of set bits gives the exact index for a legal
    // input; for illegal inputs the value is don't-care.
    always_comb begin
        index_o = 3'd0;
        for (int i = 0; i < RING_W; i++) begin
            if (hot_i[i]) begin
                index_o = index_o | 3'(i);
            end
        end
    end

    assign legal_o = is_one_hot(hot_i);

endmodule

// File: rtl/one_hot_ring_monitor.sv
// Monitor for the 8-bit one-hot rotating counter.
// Locks onto the ring, checks every sample holds or rotates left by one,
// encodes the hot position, counts revolutions and flags stalls and faults.
//   clk, reset_n : clock, asynchronous active-low reset
//   hot_in       : counter output sampled every cycle
//   up_reset     : counter's synchronous reset (unlocks, clears rev/stall)
//   err_clr      : single-cycle clear of sticky flags and FAULT state
//   index        : binary hot position, index_valid high while LOCKED
//   wrap_pulse   : one-cycle pulse after a 7->0 advance
//   rev_count    : completed revolutions (wraps modulo 2**REV_W)
//   stall        : ring held for more than STALL_MAX locked cycles
//   err_illegal  : sticky, a locked sample was not one-hot
//   err_skip     : sticky, a locked sample neither held nor advanced
// STALL_MAX must be < 2**STALL_W; STALL_MAX == 0 disables stall detection.
module one_hot_ring_monitor
    import one_hot_pkg::*;
#(
    parameter int REV_W     = 16,
    parameter int STALL_MAX = 255,
    parameter int STALL_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [RING_W-1:0] hot_in,
    input  logic              up_reset,
    input  logic              err_clr,
    output logic [2:0]        index,
    output logic              index_valid,
    output logic              wrap_pulse,
    output logic [REV_W-1:0]  rev_count,
    output logic              stall,
    output logic              err_illegal,
    output logic              err_skip
);

    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);

    ring_state_e        state_q, state_d;
    logic [RING_W-1:0]  prev_hot_q, prev_hot_d;
    logic [2:0]         index_q, index_d;
    logic               wrap_q, wrap_d;
    logic [REV_W-1:0]   rev_q, rev_d;
    logic [STALL_W-1:0] hold_q, hold_d;
    logic               stall_q, stall_d;
    logic               ill_q, ill_d;
    logic               skip_q, skip_d;

    logic [2:0] enc_index;
    logic       legal;
    logic       hold;
    logic       adv;

    one_hot_enc8 u_enc (
        .hot_i   (hot_in),
        .index_o (enc_index),
        .legal_o (legal)
    );

    assign hold = (hot_in == prev_hot_q);
    assign adv  = (hot_in == rotl1(prev_hot_q));

    always_comb begin
        state_d    = state_q;
        prev_hot_d = prev_hot_q;
        index_d    = index_q;
        wrap_d     = 1'b0;
        rev_d      = rev_q;
        hold_d     = hold_q;
        stall_d    = stall_q;
        ill_d      = ill_q;
        skip_d     = skip_q;

        // Clear first so a fault detected in the same cycle overrides it.
        if (err_clr) begin
            ill_d  = 1'b0;
            skip_d = 1'b0;
        end

        if (up_reset) begin
            // Upstream is restarting the ring: do not judge this sample.
            state_d = UNLOCKED;
            rev_d   = '0;
            hold_d  = '0;
            stall_d = 1'b0;
        end else begin
            case (state_q)
                UNLOCKED: begin
                    // Illegal samples are tolerated here (power-up garbage).
                    if (legal) begin
                        state_d    = LOCKED;
                        prev_hot_d = hot_in;
                        index_d    = enc_index;
                        hold_d     = '0;
                    end
                end
                LOCKED: begin
                    if (!legal) begin
                        ill_d   = 1'b1;
                        state_d = FAULT;
                        hold_d  = '0;
                        stall_d = 1'b0;
                    end else if (adv) begin
                        prev_hot_d = hot_in;
                        index_d    = enc_index;
                        hold_d     = '0;
                        stall_d    = 1'b0;
                        if (prev_hot_q[RING_W-1]) begin
                            wrap_d = 1'b1;
                            rev_d  = rev_q + REV_W'(1);
                        end
                    end else if (hold) begin
                        if (hold_q != STALL_LIM) begin
                            hold_d = hold_q + STALL_W'(1);
                        end
                        // Compare the pre-increment count: stall rises on
                        // the hold that follows STALL_MAX counted holds.
                        if ((STALL_MAX != 0) && (hold_q == STALL_LIM)) begin
                            stall_d = 1'b1;
                        end
                    end else begin
                        skip_d  = 1'b1;
                        state_d = FAULT;
                        hold_d  = '0;
                        stall_d = 1'b0;
                    end
                end
                FAULT: begin
                    stall_d = 1'b0;
                    if (err_clr) begin
                        state_d = UNLOCKED;
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= UNLOCKED;
            prev_hot_q <= '0;
            index_q    <= '0;
            wrap_q     <= 1'b0;
            rev_q      <= '0;
            hold_q     <= '0;
            stall_q    <= 1'b0;
            ill_q      <= 1'b0;
            skip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_hot_q <= prev_hot_d;
            index_q    <= index_d;
            wrap_q     <= wrap_d;
            rev_q      <= rev_d;
            hold_q     <= hold_d;
            stall_q    <= stall_d;
            ill_q      <= ill_d;
            skip_q     <= skip_d;
        end
    end

    assign index       = index_q;
    assign index_valid = (state_q == LOCKED);
    assign wrap_pulse  = wrap_q;
    assign rev_count   = rev_q;
    assign stall       = stall_q;
    assign err_illegal = ill_q;
    assign err_skip    = skip_q;

endmodule
